// File: rtl/sd_sector_uart_dump.sv
// Streams consecutive SD sectors from sd_reader out as gap-free 8N1 UART frames, one 512-byte buffer per sector.
// SD_DUMP_HEADER_EN: prefix each sector with its 32-bit address, big-endian (516 frames instead of 512).
module sd_sector_uart_dump #(
   parameter int UART_BPS = 921600,
   parameter int CLK_FREQ = 20_000_000,
   parameter int BAUD_DIV = CLK_FREQ / UART_BPS
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        start,
   input  logic [31:0] start_sector,
   input  logic [15:0] sector_count,
   output logic        busy,
   output logic        done,
   output logic [15:0] sectors_sent,
   output logic        rd_start,
   output logic [31:0] rd_sector,
   input  logic        rd_done,
   input  logic        rd_outen,
   input  logic [8:0]  rd_outaddr,
   input  logic [7:0]  rd_outbyte,
   output logic        tx
);
`ifdef SD_DUMP_HEADER_EN
   localparam int HDR_BYTES = 4;
`else
   localparam int HDR_BYTES = 0;
`endif
   localparam int            FRAMES    = 512 + HDR_BYTES;
   localparam int            CW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
   localparam logic [9:0]    FRM_LAST  = 10'(FRAMES - 1);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_FILL, S_SEND, S_NEXT, S_FIN} state_t;

   state_t        state_q;
   logic          busy_q;
   logic          done_q;
   logic          rd_start_q;
   logic [31:0]   rd_sector_q;
   logic [15:0]   sectors_sent_q;
   logic          tx_q;
   logic [31:0]   start_sector_q;
   logic [15:0]   count_q;
   logic [CW-1:0] baud_cnt_q;
   logic [3:0]    bit_idx_q;
   logic [9:0]    frm_idx_q;

   logic [7:0]    mem [512];
   logic [7:0]    mem_rdata_q;
   logic [8:0]    buf_raddr;
   logic          buf_we;
   logic [7:0]    frm_byte;
   logic          tx_d;

   assign buf_we    = (state_q == S_FILL) && rd_outen;
   // The read port follows the frame index; the new byte lands during the start bit,
   // so it is ready before the first data bit even at BAUD_DIV == 1.
   assign buf_raddr = frm_idx_q[8:0] - 9'(HDR_BYTES);

   always_ff @(posedge clk) begin
      if (buf_we) begin
         mem[rd_outaddr] <= rd_outbyte;
      end
      mem_rdata_q <= mem[buf_raddr];
   end

   always_comb begin
      frm_byte = mem_rdata_q;
`ifdef SD_DUMP_HEADER_EN
      case (frm_idx_q)
         10'd0:   frm_byte = rd_sector_q[31:24];
         10'd1:   frm_byte = rd_sector_q[23:16];
         10'd2:   frm_byte = rd_sector_q[15:8];
         10'd3:   frm_byte = rd_sector_q[7:0];
         default: ;
      endcase
`endif
   end

   always_comb begin
      tx_d = 1'b1;
      if (bit_idx_q == 4'd0) begin
         tx_d = 1'b0;
      end else if (bit_idx_q <= 4'd8) begin
         tx_d = frm_byte[3'(bit_idx_q - 4'd1)];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q        <= S_IDLE;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         rd_start_q     <= 1'b0;
         rd_sector_q    <= '0;
         sectors_sent_q <= '0;
         tx_q           <= 1'b1;
         start_sector_q <= '0;
         count_q        <= '0;
         baud_cnt_q     <= '0;
         bit_idx_q      <= '0;
         frm_idx_q      <= '0;
      end else begin
         done_q     <= 1'b0;
         rd_start_q <= 1'b0;
         tx_q       <= 1'b1;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  start_sector_q <= start_sector;
                  count_q        <= sector_count;
                  sectors_sent_q <= '0;
                  busy_q         <= 1'b1;
                  state_q        <= (sector_count == 16'd0) ? S_FIN : S_REQ;
               end
            end
            S_REQ: begin
               rd_start_q  <= 1'b1;
               rd_sector_q <= start_sector_q + 32'(sectors_sent_q);
               baud_cnt_q  <= '0;
               bit_idx_q   <= '0;
               frm_idx_q   <= '0;
               state_q     <= S_FILL;
            end
            S_FILL: begin
               if (rd_done) begin
                  state_q <= S_SEND;
               end
            end
            S_SEND: begin
               tx_q <= tx_d;
               if (baud_cnt_q == BAUD_LAST) begin
                  baud_cnt_q <= '0;
                  if (bit_idx_q == 4'd9) begin
                     bit_idx_q <= 4'd0;
                     if (frm_idx_q == FRM_LAST) begin
                        sectors_sent_q <= sectors_sent_q + 16'd1;
                        state_q        <= S_NEXT;
                     end else begin
                        frm_idx_q <= frm_idx_q + 10'd1;
                     end
                  end else begin
                     bit_idx_q <= bit_idx_q + 4'd1;
                  end
               end else begin
                  baud_cnt_q <= baud_cnt_q + CW'(1);
               end
            end
            S_NEXT: begin
               state_q <= (sectors_sent_q == count_q) ? S_FIN : S_REQ;
            end
            S_FIN: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign sectors_sent = sectors_sent_q;
   assign rd_start     = rd_start_q;
   assign rd_sector    = rd_sector_q;
   assign tx           = tx_q;

endmodule

// File: tb/tb_sd_sector_uart_dump.sv
// Bench for sd_sector_uart_dump: random sd_reader model plus a UART line decoder, checked against
// a byte-stream / cycle-arithmetic reference of the dump protocol.
module tb_sd_sector_uart_dump;
   localparam int CLK_FREQ = 2_000_000;
   localparam int UART_BPS = 1_000_000;
   localparam int B        = CLK_FREQ / UART_BPS;
`ifdef SD_DUMP_HEADER_EN
   localparam int FR = 516;
`else
   localparam int FR = 512;
`endif
   localparam int SEND_CYC = FR * 10 * B;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        start;
   logic [31:0] start_sector;
   logic [15:0] sector_count;
   logic        busy;
   logic        done;
   logic [15:0] sectors_sent;
   logic        rd_start;
   logic [31:0] rd_sector;
   logic        rd_done;
   logic        rd_outen;
   logic [8:0]  rd_outaddr;
   logic [7:0]  rd_outbyte;
   logic        tx;

   sd_sector_uart_dump #(.UART_BPS(UART_BPS), .CLK_FREQ(CLK_FREQ)) dut (
      .clk(clk), .rstn(rstn), .start(start), .start_sector(start_sector),
      .sector_count(sector_count), .busy(busy), .done(done), .sectors_sent(sectors_sent),
      .rd_start(rd_start), .rd_sector(rd_sector), .rd_done(rd_done), .rd_outen(rd_outen),
      .rd_outaddr(rd_outaddr), .rd_outbyte(rd_outbyte), .tx(tx)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      repeat (95000) @(posedge clk);
      $display("FAIL watchdog: cycle budget exceeded at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference traffic: what the reader hands over, and what the line must carry.
   logic        pat_mode = 1'b0;
   logic        abuse_en = 1'b0;
   int          req_n = 0;
   int          rdreq_cyc_q[$];
   logic [31:0] rdreq_sec_q[$];
   int          rddone_q[$];
   logic [7:0]  exp_q[$];
   logic [7:0]  rx_q[$];
   int          rx_cyc_q[$];
   logic        rx_good_q[$];

   initial begin : reader
      logic [31:0] sec;
      logic [7:0]  cur [512];
      logic        same;
      rd_done = 1'b0; rd_outen = 1'b0; rd_outaddr = '0; rd_outbyte = '0;
      forever begin
         @(negedge clk);
         if (rstn === 1'b1 && rd_start === 1'b1) begin
            sec = rd_sector;
            rdreq_cyc_q.push_back(cyc);
            rdreq_sec_q.push_back(sec);
            same = (req_n % 2 == 0);
            req_n++;
`ifdef SD_DUMP_HEADER_EN
            for (int i = 0; i < 4; i++) exp_q.push_back(sec[31-8*i -: 8]);
`endif
            repeat ($urandom_range(1, 4)) @(negedge clk);
            for (int a = 0; a < 512; a++) begin
               while ($urandom_range(0, 3) == 0) @(negedge clk);
               cur[a] = pat_mode ? 8'(a) : 8'($urandom);
               exp_q.push_back(cur[a]);
               rd_outen = 1'b1; rd_outaddr = 9'(a); rd_outbyte = cur[a];
               if (a == 511 && same) begin
                  rd_done = 1'b1;
                  rddone_q.push_back(cyc);
               end
               @(negedge clk);
               rd_outen = 1'b0; rd_done = 1'b0;
            end
            if (!same) begin
               repeat ($urandom_range(0, 3)) @(negedge clk);
               rd_done = 1'b1;
               rddone_q.push_back(cyc);
               @(negedge clk);
               rd_done = 1'b0;
            end
            if (abuse_en) begin
               repeat (3) @(negedge clk);
               rd_done = 1'b1; rd_outen = 1'b1; rd_outaddr = 9'd300; rd_outbyte = ~cur[300];
               @(negedge clk);
               rd_done = 1'b0; rd_outen = 1'b0;
            end
         end
      end
   end

   initial begin : uart_mon
      int         s;
      logic [7:0] d;
      logic       good;
      logic       abort;
      forever begin
         @(negedge clk);
         if (rstn === 1'b1 && tx === 1'b0) begin
            s = cyc; d = '0; good = 1'b1; abort = 1'b0;
            for (int k = 1; k < B; k++) begin
               @(negedge clk);
               if (rstn !== 1'b1) abort = 1'b1;
               if (tx !== 1'b0) good = 1'b0;
            end
            for (int i = 0; i < 8; i++) begin
               for (int k = 0; k < B; k++) begin
                  @(negedge clk);
                  if (rstn !== 1'b1) abort = 1'b1;
                  if (k == 0) d[i] = tx;
                  else if (tx !== d[i]) good = 1'b0;
               end
            end
            for (int k = 0; k < B; k++) begin
               @(negedge clk);
               if (rstn !== 1'b1) abort = 1'b1;
               if (tx !== 1'b1) good = 1'b0;
            end
            if (!abort) begin
               rx_q.push_back(d);
               rx_cyc_q.push_back(s);
               rx_good_q.push_back(good);
            end
         end
      end
   end

   task automatic flush();
      rdreq_cyc_q.delete(); rdreq_sec_q.delete(); rddone_q.delete();
      exp_q.delete(); rx_q.delete(); rx_cyc_q.delete(); rx_good_q.delete();
   endtask

   task automatic pulse_start(input logic [31:0] ss, input logic [15:0] cnt);
      start = 1'b1; start_sector = ss; sector_count = cnt;
      @(negedge clk);
      start = 1'b0; start_sector = $urandom; sector_count = 16'($urandom);
   endtask

   task automatic wait_done(input string tag, input int budget, output int dcyc);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(done === 1'b1), 32'd1);
      dcyc = cyc;
   endtask

   task automatic check_req(input string tag, input logic [31:0] ss, input int n, input int t0);
      chk({tag, "_nreq"}, rdreq_sec_q.size(), n);
      for (int i = 0; i < n && i < rdreq_sec_q.size(); i++)
         chk({tag, "_rd_sector"}, rdreq_sec_q[i], ss + 32'(i));
      if (rdreq_cyc_q.size() > 0) chk({tag, "_rd_start_lat"}, rdreq_cyc_q[0], t0 + 2);
   endtask

   task automatic check_stream(input string tag);
      int nbad = 0;
      int nframe = 0;
      chk({tag, "_nbytes"}, rx_q.size(), exp_q.size());
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
         if (rx_q[i] !== exp_q[i]) nbad++;
         if (rx_good_q[i] !== 1'b1) nframe++;
      end
      chk({tag, "_bad_bytes"}, nbad, 0);
      chk({tag, "_bad_frames"}, nframe, 0);
   endtask

   // Sector s starts 2 cycles after its rd_done and runs FR back-to-back frames; the follow-up
   // (next rd_start or done) comes 2 cycles after the last stop bit's final cycle.
   task automatic check_timing(input string tag, input int nsec, input int dcyc);
      int   gaps = 0;
      int   base;
      int   endc;
      logic complete;
      complete = (rx_cyc_q.size() >= nsec * FR) && (rddone_q.size() >= nsec) &&
                 (rdreq_cyc_q.size() >= nsec);
      chk({tag, "_timing_data"}, 32'(complete), 32'd1);
      if (complete) begin
         for (int s = 0; s < nsec; s++) begin
            base = rx_cyc_q[s*FR];
            chk({tag, "_first_start_bit"}, base, rddone_q[s] + 2);
            for (int k = 0; k < FR; k++)
               if (rx_cyc_q[s*FR+k] != base + 10*B*k) gaps++;
            endc = rx_cyc_q[(s+1)*FR-1] + 10*B + 1;
            if (s < nsec - 1) chk({tag, "_next_rd_start"}, rdreq_cyc_q[s+1], endc);
            else chk({tag, "_done_cycle"}, dcyc, endc);
         end
         chk({tag, "_frame_gaps"}, gaps, 0);
      end
   endtask

   initial begin : main
      int t0;
      int dcyc;
      int n;
      start = 1'b0; start_sector = '0; sector_count = '0;
      repeat (3) @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_start", rd_start, 0);
      chk("rst_rd_sector", rd_sector, 0);
      chk("rst_sectors_sent", sectors_sent, 0);
      rstn = 1'b1;
      repeat (2) @(negedge clk);

      // Single sector, address pattern, with stray start/rd_done/rd_outen while busy.
      flush(); pat_mode = 1'b1; abuse_en = 1'b1;
      t0 = cyc;
      pulse_start(32'h100, 16'd1);
      chk("t1_busy", busy, 1);
      repeat (8) @(negedge clk);
      pulse_start(32'h200, 16'd4);
      n = 0;
      while (rddone_q.size() == 0 && n < 3000) begin @(negedge clk); n++; end
      repeat (40) @(negedge clk);
      pulse_start(32'h300, 16'd2);
      wait_done("t1_done_seen", SEND_CYC + 3000, dcyc);
      chk("t1_busy_at_done", busy, 0);
      @(negedge clk);
      chk("t1_done_one_cycle", done, 0);
      chk("t1_sectors_sent", sectors_sent, 1);
      repeat (20) @(negedge clk);
      check_req("t1", 32'h100, 1, t0);
      check_stream("t1");
      check_timing("t1", 1, dcyc);
      abuse_en = 1'b0;

      // Three random sectors across the 32-bit address wrap.
      flush(); pat_mode = 1'b0;
      t0 = cyc;
      pulse_start(32'hFFFF_FFFE, 16'd3);
      chk("t2_busy", busy, 1);
      wait_done("t2_done_seen", 3 * SEND_CYC + 6000, dcyc);
      chk("t2_sectors_sent", sectors_sent, 3);
      repeat (20) @(negedge clk);
      check_req("t2", 32'hFFFF_FFFE, 3, t0);
      check_stream("t2");
      check_timing("t2", 3, dcyc);

      // Zero-length dump.
      flush();
      pulse_start($urandom, 16'd0);
      chk("t3_busy", busy, 1);
      @(negedge clk);
      chk("t3_done", done, 1);
      chk("t3_busy_clear", busy, 0);
      @(negedge clk);
      chk("t3_done_one_cycle", done, 0);
      repeat (30) @(negedge clk);
      chk("t3_nreq", rdreq_sec_q.size(), 0);
      chk("t3_rx_bytes", rx_q.size(), 0);
      chk("t3_tx", tx, 1);
      chk("t3_sectors_sent", sectors_sent, 0);

      // Reset during the start bit of byte 37, then a clean dump.
      flush();
      pulse_start($urandom, 16'd1);
      n = 0;
      while (!(rx_q.size() == 37 && tx === 1'b0) && n < SEND_CYC + 3000) begin
         @(negedge clk);
         n++;
      end
      chk("t4_reached_byte37", rx_q.size(), 37);
      chk("t4_tx_low_before_reset", tx, 0);
      rstn = 1'b0;
      #1;
      chk("t4_tx_async", tx, 1);
      chk("t4_busy", busy, 0);
      chk("t4_sectors_sent", sectors_sent, 0);
      chk("t4_rd_sector", rd_sector, 0);
      chk("t4_rd_start", rd_start, 0);
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      flush();
      t0 = cyc;
      pulse_start(32'h1234_5678, 16'd1);
      wait_done("t4_done_seen", SEND_CYC + 3000, dcyc);
      chk("t4_sectors_sent_after", sectors_sent, 1);
      repeat (20) @(negedge clk);
      check_req("t4", 32'h1234_5678, 1, t0);
      check_stream("t4");
      check_timing("t4", 1, dcyc);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sd_sector_uart_dump.md
# sd_sector_uart_dump

Read-back path for the SD logging system: streams a run of consecutive SD sectors out over a UART TX line. It drives the sector-read request side of `sd_reader` (start/sector/done plus the byte-output strobe) and captures each 512-byte sector into a local buffer. It then serializes that buffer as 8N1 UART frames before requesting the next sector. It sits beside the write path and dumps logged data to the host at the same baud rate the logger receives it.

## Interface
Parameters:
- UART_BPS, 921600, line rate.
- CLK_FREQ, 20_000_000, clk frequency in Hz.
- BAUD_DIV, CLK_FREQ/UART_BPS (integer truncation; 21 at defaults), clk cycles per UART bit.

Ports:
- clk  input  1  system clock.
- rstn  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle request to begin a dump; honoured only in IDLE.
- start_sector  input  32  first sector address; sampled with start.
- sector_count  input  16  number of sectors to dump; sampled with start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when the dump completes.
- sectors_sent  output  16  count of sectors fully transmitted; cleared on accepted start.
- rd_start  output  1  one-cycle read request to `sd_reader`.
- rd_sector  output  32  sector address; held stable from rd_start until rd_done.
- rd_done  input  1  sector read complete.
- rd_outen  input  1  byte valid strobe from the reader.
- rd_outaddr  input  9  byte index 0..511 within the sector.
- rd_outbyte  input  8  byte data.
- tx  output  1  UART serial out, idle high.

## Operation
- Buffer: 512x8, written at rd_outaddr when rd_outen is high and state is FILL; read synchronously with 1-cycle latency.
- States:
  - IDLE: on start, latch sector/count, clear sectors_sent, assert busy. If count==0, go to FIN; else go to REQ.
  - REQ: pulse rd_start for 1 cycle with rd_sector = start_sector + sectors_sent (32-bit wrap), then go to FILL.
  - FILL: capture bytes. On rd_done go to SEND; a byte strobed in the same cycle as rd_done is still written.
  - SEND: transmit buffer bytes 0..511 in order. Each frame is 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each bit lasting BAUD_DIV cycles. The next byte is prefetched, so the next start bit follows the previous stop bit with no gap. After the stop bit of byte 511, increment sectors_sent and go to NEXT.
  - NEXT: if sectors_sent == latched count, go to FIN; else go to REQ.
  - FIN: pulse done, deassert busy, go to IDLE.
- Ignored inputs: start outside IDLE; rd_done/rd_outen outside FILL.
- No timeout: a missing rd_done leaves the block in FILL until reset.

## Timing
- Reset values: tx=1, busy=0, done=0, rd_start=0, rd_sector=0, sectors_sent=0, state IDLE. Buffer contents are undefined.
- start at cycle T: busy=1 at T+1; rd_start at T+2.
- rd_done at cycle R: first start bit (tx falls) at R+2.
- Per sector, SEND lasts exactly 512*10*BAUD_DIV cycles (107520 at defaults).
- Sector n+1's rd_start is issued 2 cycles after sector n's final stop bit ends.
- count==0: done pulses at T+2; rd_start is never asserted; tx stays high.
- Reset asserted mid-frame: tx returns high immediately (asynchronously) and all outputs take their reset values. A partial frame is truncated.

## Configuration
- SD_DUMP_HEADER_EN defined: each sector's payload is preceded by a 4-byte header containing the current rd_sector value, big-endian. SEND covers 516 frames; the first start bit still occurs at R+2.
- Macro undefined: payload only, 512 frames per sector; no header logic is synthesized.

## Test plan
- Single sector: start_sector=0x100, count=1, reader returns byte = addr[7:0] -> exactly one rd_start with rd_sector=0x100. The UART monitor decodes 00..FF twice. done pulses 107520+2 cycles after rd_done (plus stop-bit end); sectors_sent=1.
- Multi-sector: count=3 -> rd_sector 0x100, 0x101, 0x102 in order. Each rd_start follows the previous sector's last stop bit by 2 cycles; 1536 bytes are received; sectors_sent=3.
- Zero count: start with count=0 -> done at T+2; no rd_start; tx constant 1; busy returns to 0.
- Protocol abuse: extra start pulses during FILL/SEND, and a stray rd_done plus rd_outen during SEND -> no extra rd_start; buffer contents and UART output unchanged.
- Reset during SEND at byte 37: tx=1, busy=0, sectors_sent=0. A subsequent start with count=1 produces a clean full dump.
- With SD_DUMP_HEADER_EN: start_sector=0x12345678, count=1 -> bytes 12 34 56 78 followed by the 512 payload bytes (516 total).
